// File: rtl/onehot_decoder_reg.sv
// Registered binary-to-one-hot decoder with true/complement outputs, a valid/ready input,
// level or fixed-length pulse output, synchronous clear and out-of-range code flagging.
module onehot_decoder_reg #(
  parameter int SEL_W     = 2,
  parameter int OUT_W     = 4,
  parameter int PULSE_LEN = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SEL_W-1:0] code_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic             mode_i,
  input  logic             clr_i,
  output logic [OUT_W-1:0] y,
  output logic [OUT_W-1:0] yn,
  output logic             err_o,
  output logic             busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_PULSE = 2'd2
  } state_t;

  localparam int               CNT_W    = 8;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(PULSE_LEN - 1);

  state_t           state_r, state_s;
  logic [OUT_W-1:0] y_r, y_s;
  logic             err_r, err_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic             code_ok_s;
  logic             accept_s;

  // Codes beyond the last output decode to all zeros, so no separate masking is needed.
  function automatic logic [OUT_W-1:0] decode(input logic [SEL_W-1:0] c);
    logic [OUT_W-1:0] d;
    d = '0;
    for (int i = 0; i < OUT_W; i++) begin
      d[i] = (c == SEL_W'(i));
    end
    return d;
  endfunction

  // State, output and pulse-counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      y_r     <= '0;
      err_r   <= 1'b0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      y_r     <= y_s;
      err_r   <= err_s;
      cnt_r   <= cnt_s;
    end
  end

  assign code_ok_s = ({1'b0, code_i} < (SEL_W + 1)'(OUT_W));
  assign accept_s  = valid_i && ready_o && !clr_i;

  // Next-state logic; clear overrides both accepts and the running pulse.
  always_comb begin
    state_s = state_r;
    y_s     = y_r;
    err_s   = err_r;
    cnt_s   = cnt_r;
    if (clr_i) begin
      state_s = ST_IDLE;
      y_s     = '0;
      err_s   = 1'b0;
      cnt_s   = '0;
    end else begin
      case (state_r)
        ST_PULSE: begin
          if (cnt_r == '0) begin
            state_s = ST_IDLE;
            y_s     = '0;
          end else begin
            cnt_s = cnt_r - CNT_W'(1);
          end
        end
        ST_IDLE, ST_HOLD: begin
          if (accept_s && code_ok_s) begin
            y_s   = decode(code_i);
            err_s = 1'b0;
            if (mode_i) begin
              state_s = ST_PULSE;
              cnt_s   = CNT_LOAD;
            end else begin
              state_s = ST_HOLD;
              cnt_s   = '0;
            end
          end else if (accept_s) begin
            state_s = ST_IDLE;
            y_s     = '0;
            err_s   = 1'b1;
            cnt_s   = '0;
          end else begin
            state_s = state_r;
          end
        end
        default: begin
          state_s = ST_IDLE;
          y_s     = '0;
          cnt_s   = '0;
        end
      endcase
    end
  end

  // Output decode; yn comes from the y register so the pair can never disagree.
  always_comb begin
    busy_o  = (state_r == ST_PULSE);
    ready_o = !busy_o;
    y       = y_r;
    yn      = ~y_r;
    err_o   = err_r;
  end

endmodule

// File: tb/tb_onehot_decoder_reg.sv
// Bench for onehot_decoder_reg: two instances (full and partial code range) driven
// with the same stimulus and compared every cycle against a cycle-count reference model.
module tb_onehot_decoder_reg;

  logic       clk = 1'b0;
  logic       rst_n, valid, mode, clr;
  logic [1:0] code;
  logic       ready_a, err_a, busy_a, ready_b, err_b, busy_b;
  logic [3:0] y_a, yn_a;
  logic [2:0] y_b, yn_b;

  int n_cmp = 0;
  int n_fail = 0;

  // Reference model per instance: index of the asserted output (-1 none), sticky error,
  // and remaining cycles the pulse output stays high.
  int ow[2] = '{4, 3};
  int pl[2] = '{3, 4};
  int m_idx[2];
  int m_err[2];
  int m_left[2];

  always #5 clk = ~clk;

  onehot_decoder_reg #(.SEL_W(2), .OUT_W(4), .PULSE_LEN(3)) dut_a (
    .clk(clk), .rst_n(rst_n), .code_i(code), .valid_i(valid), .ready_o(ready_a),
    .mode_i(mode), .clr_i(clr), .y(y_a), .yn(yn_a), .err_o(err_a), .busy_o(busy_a));

  onehot_decoder_reg #(.SEL_W(2), .OUT_W(3), .PULSE_LEN(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .code_i(code), .valid_i(valid), .ready_o(ready_b),
    .mode_i(mode), .clr_i(clr), .y(y_b), .yn(yn_b), .err_o(err_b), .busy_o(busy_b));

  function automatic logic [3:0] onehot(int idx);
    logic [3:0] v;
    v = 4'b0000;
    if (idx >= 0) v[idx] = 1'b1;
    return v;
  endfunction

  // Expected {y, yn, err, busy, ready} for each instance.
  function automatic logic [10:0] exp_a();
    logic [3:0] e;
    e = onehot(m_idx[0]);
    return {e, ~e, m_err[0] != 0, m_left[0] > 0, m_left[0] == 0};
  endfunction

  function automatic logic [8:0] exp_b();
    logic [3:0] e;
    logic [2:0] e3;
    e = onehot(m_idx[1]);
    e3 = e[2:0];
    return {e3, ~e3, m_err[1] != 0, m_left[1] > 0, m_left[1] == 0};
  endfunction

  task automatic step();
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst_n || clr) begin
        m_idx[i] = -1; m_err[i] = 0; m_left[i] = 0;
      end else if (m_left[i] > 0) begin
        m_left[i]--;
        if (m_left[i] == 0) m_idx[i] = -1;
      end else if (valid) begin
        if (int'(code) < ow[i]) begin
          m_idx[i] = int'(code); m_err[i] = 0; m_left[i] = mode ? pl[i] : 0;
        end else begin
          m_idx[i] = -1; m_err[i] = 1; m_left[i] = 0;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; valid = 1'b1; code = 2'd3; mode = 1'b0; clr = 1'b0;
    step(); step();
    n_cmp++;
    if ({y_a, yn_a, err_a} !== {4'b0000, 4'b1111, 1'b0}) begin
      n_fail++; $display("FAIL reset_a got %b/%b/%b want 0000/1111/0", y_a, yn_a, err_a);
    end
    n_cmp++;
    if ({y_b, yn_b, err_b} !== {3'b000, 3'b111, 1'b0}) begin
      n_fail++; $display("FAIL reset_b got %b/%b/%b want 000/111/0", y_b, yn_b, err_b);
    end
    valid = 1'b0; rst_n = 1'b1;
    step();
    n_cmp++;
    if ({ready_a, ready_b, y_a} !== {1'b1, 1'b1, 4'b0000}) begin
      n_fail++; $display("FAIL reset_release got rdy %b%b y %b want 11 0000", ready_a, ready_b, y_a);
    end
  endtask

  task automatic test_level();
    logic [3:0] want;
    valid = 1'b1; mode = 1'b0;
    for (int c = 0; c < 4; c++) begin
      code = 2'(c);
      step();
      want = 4'b0001 << c;
      n_cmp++;
      if ({y_a, yn_a, ready_a} !== {want, ~want, 1'b1}) begin
        n_fail++; $display("FAIL level_code%0d got y=%b yn=%b rdy=%b want y=%b", c, y_a, yn_a, ready_a, want);
      end
      n_cmp++;
      if ({y_b, yn_b, err_b, busy_b, ready_b} !== exp_b()) begin
        n_fail++; $display("FAIL level_b_code%0d got %b want %b", c, {y_b, yn_b, err_b, busy_b, ready_b}, exp_b());
      end
    end
    valid = 1'b0;
    step();
  endtask

  task automatic test_pulse();
    int high = 0;
    valid = 1'b1; mode = 1'b1; code = 2'd2;
    step();
    if (y_a == 4'b0100) high++;
    code = 2'd1; mode = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (k < 3) begin
        n_cmp++;
        if ({busy_a, ready_a} !== 2'b10) begin
          n_fail++; $display("FAIL pulse_busy cycle %0d got busy/rdy %b%b want 10", k, busy_a, ready_a);
        end
      end
      step();
      if (y_a == 4'b0100) high++;
      n_cmp++;
      if ({y_a, yn_a, err_a, busy_a, ready_a} !== exp_a()) begin
        n_fail++; $display("FAIL pulse_model_a k=%0d got %b want %b", k, {y_a, yn_a, err_a, busy_a, ready_a}, exp_a());
      end
    end
    n_cmp++;
    if (high != 3 || y_a !== 4'b0010) begin
      n_fail++; $display("FAIL pulse_len got high=%0d y=%b want 3 cycles then 0010", high, y_a);
    end
    valid = 1'b0;
    for (int k = 0; k < 5; k++) step();
  endtask

  task automatic test_out_of_range();
    valid = 1'b1; mode = 1'b0; code = 2'd3;
    step();
    n_cmp++;
    if ({y_b, yn_b, err_b} !== {3'b000, 3'b111, 1'b1}) begin
      n_fail++; $display("FAIL oor_code3 got %b/%b/%b want 000/111/1", y_b, yn_b, err_b);
    end
    code = 2'd1;
    step();
    n_cmp++;
    if ({y_b, err_b} !== {3'b010, 1'b0}) begin
      n_fail++; $display("FAIL oor_recover got y=%b err=%b want 010 0", y_b, err_b);
    end
    valid = 1'b0;
    step();
  endtask

  task automatic test_clear_mid_pulse();
    valid = 1'b1; mode = 1'b1; code = 2'd1;
    step();
    valid = 1'b0;
    step();
    clr = 1'b1; valid = 1'b1; code = 2'd2;
    step();
    n_cmp++;
    if ({y_b, busy_b, err_b} !== {3'b000, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL clr_pulse got y=%b busy=%b err=%b want 000 0 0", y_b, busy_b, err_b);
    end
    clr = 1'b0; valid = 1'b0;
    n_cmp++;
    if ({ready_b, y_a} !== {1'b1, 4'b0000}) begin
      n_fail++; $display("FAIL clr_ready got rdy=%b y_a=%b want 1 0000", ready_b, y_a);
    end
    step();
  endtask

  task automatic test_reset_mid_pulse();
    valid = 1'b1; mode = 1'b1; code = 2'd2;
    step();
    valid = 1'b0; rst_n = 1'b0;
    step();
    n_cmp++;
    if ({y_a, busy_a, y_b, busy_b} !== {4'b0000, 1'b0, 3'b000, 1'b0}) begin
      n_fail++; $display("FAIL rst_pulse got a=%b/%b b=%b/%b want zeros", y_a, busy_a, y_b, busy_b);
    end
    rst_n = 1'b1; valid = 1'b1; mode = 1'b0; code = 2'd0;
    step();
    n_cmp++;
    if (y_a !== 4'b0001) begin
      n_fail++; $display("FAIL rst_then_level got y=%b want 0001", y_a);
    end
    valid = 1'b0;
    step();
  endtask

  task automatic test_random();
    for (int k = 0; k < 400; k++) begin
      valid = ($urandom_range(0, 3) != 0);
      code  = 2'($urandom_range(0, 3));
      mode  = ($urandom_range(0, 2) == 0);
      clr   = ($urandom_range(0, 19) == 0);
      rst_n = ($urandom_range(0, 49) != 0);
      step();
      n_cmp++;
      if ({y_a, yn_a, err_a, busy_a, ready_a} !== exp_a()) begin
        n_fail++; $display("FAIL random_a k=%0d got %b want %b", k, {y_a, yn_a, err_a, busy_a, ready_a}, exp_a());
      end
      n_cmp++;
      if ({y_b, yn_b, err_b, busy_b, ready_b} !== exp_b()) begin
        n_fail++; $display("FAIL random_b k=%0d got %b want %b", k, {y_b, yn_b, err_b, busy_b, ready_b}, exp_b());
      end
    end
    rst_n = 1'b1; clr = 1'b0; valid = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_idx[i] = -1; m_err[i] = 0; m_left[i] = 0;
    end
    @(negedge clk);
    test_reset();
    test_level();
    test_pulse();
    test_out_of_range();
    test_clear_mid_pulse();
    test_reset_mid_pulse();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_decoder_reg.md
Name: onehot_decoder_reg

Overview:
- Parametrised, registered successor to the team's 2:4 behavioural decoder: binary code to one-hot output, with true and complement outputs.
- Adds a valid/ready input handshake, a level or pulse output mode, synchronous clear, and out-of-range code detection.
- Sits between control FSMs and select/strobe lines (mux selects, bank enables, one-shot triggers).

Parameters:
- SEL_W, 2, width of binary code input (1..6).
- OUT_W, 4, number of one-hot outputs (1..2**SEL_W); codes >= OUT_W are invalid.
- PULSE_LEN, 1, cycles a pulse-mode output stays asserted (1..255).

Ports:
- clk  input  1  single clock; all logic on rising edge.
- rst_n  input  1  synchronous, active-low reset.
- code_i  input  SEL_W  binary code to decode.
- valid_i  input  1  code_i is valid this cycle.
- ready_o  output  1  block can accept a code this cycle.
- mode_i  input  1  0 = level (hold), 1 = pulse; sampled only on accept.
- clr_i  input  1  synchronous clear of outputs and state.
- y  output  OUT_W  registered one-hot output.
- yn  output  OUT_W  bitwise complement of y, always ~y.
- err_o  output  1  sticky flag: last accepted code was out of range.
- busy_o  output  1  pulse in progress.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-low (rst_n), sampled on the rising edge.
- Reset values: y = 0, yn = all ones, err_o = 0, busy_o = 0, state = IDLE, pulse counter = 0.
- Accept: accept = valid_i && ready_o && !clr_i.
- ready_o is combinational: ready_o = !busy_o.
  - In level mode ready_o stays 1, so a new code may replace the held one every cycle.
- Latency: a code accepted at edge k appears on y/yn immediately after edge k (1-cycle registered latency). No combinational path from code_i to y.
- Decode: if code_i < OUT_W, y <= 1 << code_i and err_o <= 0. Otherwise y <= 0 and err_o <= 1, and state goes to IDLE regardless of mode.
- States:
  - IDLE: y = 0.
    - On a valid-code accept with mode_i = 0, go to HOLD.
    - On a valid-code accept with mode_i = 1, go to PULSE and load counter = PULSE_LEN-1.
  - HOLD: y holds the last code.
    - A new accept re-decodes; mode_i = 1 moves to PULSE.
    - An invalid code clears y and returns to IDLE.
  - PULSE: busy_o = 1, ready_o = 0, y held.
    - Counter decrements each cycle.
    - When counter = 0 at an edge, y <= 0, go to IDLE, busy_o <= 0. The following cycle ready_o = 1.
    - Result: y is high exactly PULSE_LEN cycles.
    - mode_i changes during PULSE are ignored.
- clr_i has priority over accept and over the pulse counter. On the next edge: y = 0, err_o = 0, busy_o = 0, state = IDLE, counter = 0.
- rst_n low has priority over clr_i.
- Reset mid-pulse aborts the pulse; outputs take reset values on that edge.
- yn is derived from registered y, never independently registered, so y ^ yn = all ones at all times.
- With OUT_W = 2**SEL_W, err_o can never assert.
- valid_i held with ready_o = 0: no accept; the code is not queued; the source must hold it until ready_o = 1.

Test Plan:
- Reset: hold rst_n = 0 for 2 cycles with valid_i = 1, code 3 -> y = 0000, yn = 1111, err_o = 0, ready_o = 1 after release.
- Level mode (SEL_W=2, OUT_W=4): accept codes 0, 1, 2, 3 on consecutive cycles -> y = 0001, 0010, 0100, 1000 each one cycle after accept, yn = ~y, ready_o always 1.
- Pulse mode (PULSE_LEN=3): accept code 2 with mode 1 -> y = 0100 for exactly 3 cycles, then 0000. busy_o = 1 and ready_o = 0 during those 3 cycles. valid_i held with code 1 is accepted on the 4th cycle after the first accept.
- Out-of-range (OUT_W=3): accept code 3 -> y = 000, yn = 111, err_o = 1. Then accept code 1 -> y = 010, err_o = 0.
- clr_i mid-pulse (PULSE_LEN=4): accept code 1 in pulse mode, assert clr_i on cycle 2 together with valid_i -> y = 0000 and busy_o = 0 next edge, no accept that cycle, ready_o = 1 the cycle after.
- Reset mid-pulse: rst_n = 0 during PULSE -> y = 0, busy_o = 0 at the next edge. After release, a level accept of code 0 gives y = 0001.
